// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between the VGA timing generator (master) and the
// pixel-generation logic (slave). The slave side supplies the run enable.
interface vga_timing_gen_if #(
  parameter int unsigned CW = 10
);
  logic          enable;
  logic          p_tick;
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic          hsync;
  logic          vsync;
  logic          video_on;
  logic          line_start;
  logic          frame_start;

  modport master (
    input  enable,
    output p_tick, x, y, hsync, vsync, video_on, line_start, frame_start
  );

  modport slave (
    output enable,
    input  p_tick, x, y, hsync, vsync, video_on, line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel-rate divider, x/y raster
// counters, registered sync/video decode with optional pixel-delay pipeline.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter bit          HSYNC_POL = 1'b0,
  parameter bit          VSYNC_POL = 1'b0,
  parameter int unsigned PIPE_DLY  = 0,
  parameter int unsigned CW        = 10
) (
  input  logic             clk_100MHz,
  input  logic             reset,
  vga_timing_gen_if.master tmg
);

  localparam int unsigned HT     = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned VT     = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS_BEG = H_ACTIVE + H_FRONT;
  localparam int unsigned HS_END = HS_BEG + H_SYNC;
  localparam int unsigned VS_BEG = V_ACTIVE + V_FRONT;
  localparam int unsigned VS_END = VS_BEG + V_SYNC;
  localparam int unsigned DW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] X_LAST   = CW'(HT - 1);
  localparam logic [CW-1:0] Y_LAST   = CW'(VT - 1);
  localparam bit            TICK_RST = (CLK_DIV == 1);

  typedef struct packed {
    logic video_on;
    logic vsync;
    logic hsync;
  } dec_t;

  localparam dec_t DEC_IDLE = '{video_on: 1'b0, vsync: ~VSYNC_POL, hsync: ~HSYNC_POL};

  logic [DW-1:0] div_q, div_d;
  logic          p_tick_q, p_tick_d;
  logic [CW-1:0] x_q, x_d;
  logic [CW-1:0] y_q, y_d;
  logic          line_q, line_d;
  logic          frame_q, frame_d;
  logic          x_wrap, y_wrap;
  dec_t          pipe_q [PIPE_DLY+1];
  dec_t          pipe_d [PIPE_DLY+1];

  // Pin-level sync/video decode for a raster position.
  function automatic dec_t decode(input logic [CW-1:0] xv, input logic [CW-1:0] yv);
    dec_t d;
    d.hsync    = ((32'(xv) >= HS_BEG) && (32'(xv) < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
    d.vsync    = ((32'(yv) >= VS_BEG) && (32'(yv) < VS_END)) ? VSYNC_POL : ~VSYNC_POL;
    d.video_on = (32'(xv) < H_ACTIVE) && (32'(yv) < V_ACTIVE);
    return d;
  endfunction

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      div_q    <= '0;
      p_tick_q <= TICK_RST;
      x_q      <= '0;
      y_q      <= '0;
      line_q   <= 1'b0;
      frame_q  <= 1'b0;
      for (int unsigned i = 0; i <= PIPE_DLY; i++) pipe_q[i] <= DEC_IDLE;
    end else begin
      div_q    <= div_d;
      p_tick_q <= p_tick_d;
      x_q      <= x_d;
      y_q      <= y_d;
      line_q   <= line_d;
      frame_q  <= frame_d;
      for (int unsigned i = 0; i <= PIPE_DLY; i++) pipe_q[i] <= pipe_d[i];
    end
  end

  // Next-state: decode and pipeline move only on advance edges so the
  // outputs stay deasserted until the first pixel after (re)start.
  always_comb begin
    div_d    = div_q;
    p_tick_d = p_tick_q;
    x_d      = x_q;
    y_d      = y_q;
    line_d   = 1'b0;
    frame_d  = 1'b0;
    x_wrap   = (x_q == X_LAST);
    y_wrap   = (y_q == Y_LAST);
    for (int unsigned i = 0; i <= PIPE_DLY; i++) pipe_d[i] = pipe_q[i];

    if (!tmg.enable) begin
      div_d    = '0;
      p_tick_d = TICK_RST;
      x_d      = '0;
      y_d      = '0;
      for (int unsigned i = 0; i <= PIPE_DLY; i++) pipe_d[i] = DEC_IDLE;
    end else begin
      div_d    = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
      p_tick_d = (div_d == DIV_LAST);
      if (p_tick_q) begin
        x_d = x_wrap ? '0 : x_q + 1'b1;
        if (x_wrap) y_d = y_wrap ? '0 : y_q + 1'b1;
        line_d  = x_wrap;
        frame_d = x_wrap && y_wrap;
        pipe_d[0] = decode(x_d, y_d);
        for (int unsigned i = 1; i <= PIPE_DLY; i++) pipe_d[i] = pipe_q[i-1];
      end
    end
  end

  assign tmg.p_tick      = p_tick_q;
  assign tmg.x           = x_q;
  assign tmg.y           = y_q;
  assign tmg.line_start  = line_q;
  assign tmg.frame_start = frame_q;
  assign tmg.hsync       = pipe_q[PIPE_DLY].hsync;
  assign tmg.vsync       = pipe_q[PIPE_DLY].vsync;
  assign tmg.video_on    = pipe_q[PIPE_DLY].video_on;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: four configurations on one clock,
// checked at hand-computed clk-edge counts after reset release.
module tb_vga_timing_gen;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic rst_d = 1'b1;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  vga_timing_gen_if #(.CW(10)) if_a ();
  vga_timing_gen_if #(.CW(10)) if_b ();
  vga_timing_gen_if #(.CW(10)) if_c ();
  vga_timing_gen_if #(.CW(10)) if_d ();

  // A: default 640x480 mode.
  vga_timing_gen u_a (.clk_100MHz(clk), .reset(rst), .tmg(if_a));

  // B: positive syncs, two-pixel output delay.
  vga_timing_gen #(.HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .PIPE_DLY(2))
    u_b (.clk_100MHz(clk), .reset(rst), .tmg(if_b));

  // C: one clk per pixel, tiny 14x7 raster.
  vga_timing_gen #(.CLK_DIV(1), .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
                   .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1))
    u_c (.clk_100MHz(clk), .reset(rst), .tmg(if_c));

  // D: tiny raster at CLK_DIV=4 (392 clks per frame), own reset.
  vga_timing_gen #(.CLK_DIV(4), .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
                   .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1))
    u_d (.clk_100MHz(clk), .reset(rst_d), .tmg(if_d));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after clk edge number 'target' since release.
  task automatic step_to(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  initial begin
    if_a.enable = 1'b1;
    if_b.enable = 1'b1;
    if_c.enable = 1'b1;
    if_d.enable = 1'b1;
    #23;
    chk("a_rst_x",      32'(if_a.x), 0);
    chk("a_rst_y",      32'(if_a.y), 0);
    chk("a_rst_ptick",  32'(if_a.p_tick), 0);
    chk("a_rst_hsync",  32'(if_a.hsync), 1);
    chk("a_rst_vsync",  32'(if_a.vsync), 1);
    chk("a_rst_video",  32'(if_a.video_on), 0);
    chk("a_rst_line",   32'(if_a.line_start), 0);
    chk("a_rst_frame",  32'(if_a.frame_start), 0);
    chk("b_rst_hsync",  32'(if_b.hsync), 0);
    chk("b_rst_vsync",  32'(if_b.vsync), 0);
    chk("c_rst_ptick",  32'(if_c.p_tick), 1);
    chk("d_rst_frame",  32'(if_d.frame_start), 0);
    rst   = 1'b0;
    rst_d = 1'b0;

    step_to(2);   chk("a_ptick_e2", 32'(if_a.p_tick), 0);
                  chk("a_x_e2",     32'(if_a.x), 0);
    step_to(3);   chk("a_ptick_e3", 32'(if_a.p_tick), 1);
    step_to(4);   chk("a_x_e4",     32'(if_a.x), 1);
                  chk("a_ptick_e4", 32'(if_a.p_tick), 0);
                  chk("a_video_e4", 32'(if_a.video_on), 1);
    step_to(7);   chk("a_ptick_e7", 32'(if_a.p_tick), 1);
                  chk("c_x_e7",     32'(if_c.x), 7);
                  chk("c_video_e7", 32'(if_c.video_on), 1);
    step_to(8);   chk("b_video_e8", 32'(if_b.video_on), 0);
                  chk("c_video_e8", 32'(if_c.video_on), 0);
    step_to(9);   chk("c_hs_x9",    32'(if_c.hsync), 1);
    step_to(10);  chk("c_hs_x10",   32'(if_c.hsync), 0);
    step_to(12);  chk("b_video_e12",32'(if_b.video_on), 1);
                  chk("c_hs_x12",   32'(if_c.hsync), 0);
    step_to(13);  chk("c_hs_x13",   32'(if_c.hsync), 1);
                  chk("c_ptick_e13",32'(if_c.p_tick), 1);
    step_to(56);  chk("c_y_e56",    32'(if_c.y), 4);
                  chk("c_video_y4", 32'(if_c.video_on), 0);
    step_to(69);  chk("c_vs_y4",    32'(if_c.vsync), 1);
    step_to(70);  chk("c_vs_y5",    32'(if_c.vsync), 0);
    step_to(84);  chk("c_vs_y6",    32'(if_c.vsync), 1);
    step_to(97);  chk("c_frame_e97",32'(if_c.frame_start), 0);
    step_to(98);  chk("c_frame_e98",32'(if_c.frame_start), 1);
                  chk("c_line_e98", 32'(if_c.line_start), 1);
                  chk("c_x_e98",    32'(if_c.x), 0);
                  chk("c_y_e98",    32'(if_c.y), 0);
                  chk("c_ptick_e98",32'(if_c.p_tick), 1);
    step_to(99);  chk("c_frame_e99",32'(if_c.frame_start), 0);
    step_to(196); chk("c_frame_e196",32'(if_c.frame_start), 1);

    step_to(391); chk("d_frame_e391",32'(if_d.frame_start), 0);
    step_to(392); chk("d_frame_e392",32'(if_d.frame_start), 1);
                  chk("d_line_e392", 32'(if_d.line_start), 1);
    step_to(393); chk("d_frame_e393",32'(if_d.frame_start), 0);
    step_to(400); chk("d_x_e400",    32'(if_d.x), 2);
    if_d.enable = 1'b0;
    step_to(401); chk("d_gap_x",     32'(if_d.x), 0);
                  chk("d_gap_y",     32'(if_d.y), 0);
                  chk("d_gap_ptick", 32'(if_d.p_tick), 0);
                  chk("d_gap_video", 32'(if_d.video_on), 0);
    step_to(405);
    if_d.enable = 1'b1;
    step_to(409); chk("d_restart_x", 32'(if_d.x), 1);
                  chk("d_restart_fr",32'(if_d.frame_start), 0);
    step_to(796); chk("d_frame_e796",32'(if_d.frame_start), 0);
    step_to(797); chk("d_frame_e797",32'(if_d.frame_start), 1);
    step_to(1185);chk("d_x_last",    32'(if_d.x), 13);
                  chk("d_y_last",    32'(if_d.y), 6);
    step_to(1186);
    rst_d = 1'b1;
    #1;           chk("d_arst_x",    32'(if_d.x), 0);
                  chk("d_arst_y",    32'(if_d.y), 0);
                  chk("d_arst_hs",   32'(if_d.hsync), 1);
                  chk("d_arst_vs",   32'(if_d.vsync), 1);
                  chk("d_arst_ptick",32'(if_d.p_tick), 0);
    step_to(1189);chk("d_arst_fr89", 32'(if_d.frame_start), 0);
    step_to(1190);chk("d_arst_fr90", 32'(if_d.frame_start), 0);
                  chk("d_arst_line", 32'(if_d.line_start), 0);
    rst_d = 1'b0;

    step_to(2556);chk("a_video_x639",32'(if_a.video_on), 1);
    step_to(2560);chk("a_video_x640",32'(if_a.video_on), 0);
    step_to(2564);chk("b_video_x641",32'(if_b.video_on), 1);
    step_to(2568);chk("b_video_x642",32'(if_b.video_on), 0);
    step_to(2620);chk("a_hs_x655",   32'(if_a.hsync), 1);
    step_to(2624);chk("a_hs_x656",   32'(if_a.hsync), 0);
    step_to(2628);chk("b_hs_x657",   32'(if_b.hsync), 0);
    step_to(2632);chk("b_hs_x658",   32'(if_b.hsync), 1);
    step_to(3004);chk("a_hs_x751",   32'(if_a.hsync), 0);
    step_to(3008);chk("a_hs_x752",   32'(if_a.hsync), 1);
    step_to(3012);chk("b_hs_x753",   32'(if_b.hsync), 1);
    step_to(3016);chk("b_hs_x754",   32'(if_b.hsync), 0);
    step_to(3196);chk("a_x_e3196",   32'(if_a.x), 799);
                  chk("a_line_e3196",32'(if_a.line_start), 0);
    step_to(3200);chk("a_x_wrap",    32'(if_a.x), 0);
                  chk("a_y_e3200",   32'(if_a.y), 1);
                  chk("a_line_e3200",32'(if_a.line_start), 1);
                  chk("a_frame_e3200",32'(if_a.frame_start), 0);
                  chk("a_video_y1",  32'(if_a.video_on), 1);
    step_to(3201);chk("a_line_e3201",32'(if_a.line_start), 0);
    step_to(6400);chk("a_line_e6400",32'(if_a.line_start), 1);
                  chk("a_y_e6400",   32'(if_a.y), 2);
    step_to(7600);chk("a_x_e7600",   32'(if_a.x), 300);
    if_a.enable = 1'b0;
    step_to(7601);chk("a_gap_x",     32'(if_a.x), 0);
                  chk("a_gap_y",     32'(if_a.y), 0);
                  chk("a_gap_ptick", 32'(if_a.p_tick), 0);
                  chk("a_gap_video", 32'(if_a.video_on), 0);
                  chk("a_gap_hs",    32'(if_a.hsync), 1);
                  chk("a_gap_vs",    32'(if_a.vsync), 1);
    step_to(7605);chk("a_gap_line",  32'(if_a.line_start), 0);
    if_a.enable = 1'b1;
    step_to(7608);chk("a_re_ptick",  32'(if_a.p_tick), 1);
    step_to(7609);chk("a_re_x",      32'(if_a.x), 1);
                  chk("a_re_frame",  32'(if_a.frame_start), 0);
                  chk("a_re_video",  32'(if_a.video_on), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator clocked from the board's 100 MHz clock. It derives a pixel-rate enable, runs horizontal and vertical raster counters, and produces sync, blanking and frame/line markers. Sync polarity, porch and sync widths, the clock divider and the sync/video pipeline delay are all configurable, so the block can drive any VESA mode. It sits between the clock input and the pixel-generation logic, which consumes `x`, `y`, `p_tick` and the markers.

## Interface
- `CLK_DIV`, 4: clk_100MHz cycles per pixel; ≥1.
- `H_ACTIVE`, 640: visible pixels per line.
- `H_FRONT`, 16: horizontal front porch, pixels.
- `H_SYNC`, 96: horizontal sync width, pixels.
- `H_BACK`, 48: horizontal back porch, pixels.
- `V_ACTIVE`, 480: visible lines per frame.
- `V_FRONT`, 10: vertical front porch, lines.
- `V_SYNC`, 2: vertical sync width, lines.
- `V_BACK`, 33: vertical back porch, lines.
- `HSYNC_POL`, 0: asserted hsync level (0 = active-low).
- `VSYNC_POL`, 0: asserted vsync level.
- `PIPE_DLY`, 0: pixels by which hsync/vsync/video_on lag x/y; range 0–7.
- `CW`, 10: counter width; H total ≤ 2^CW and V total ≤ 2^CW.

Ports:
- `clk_100MHz` in 1: system clock.
- `reset` in 1: asynchronous, active-high.
- `enable` in 1: run when high; synchronous soft restart when low.
- `p_tick` out 1: pixel enable, high one clk cycle in every CLK_DIV cycles.
- `x` out CW: horizontal count, 0..HT-1, where HT = sum of the H_* parameters.
- `y` out CW: vertical count, 0..VT-1, where VT = sum of the V_* parameters.
- `hsync` out 1: horizontal sync at the configured polarity.
- `vsync` out 1: vertical sync at the configured polarity.
- `video_on` out 1: high in the visible region.
- `line_start` out 1: one-clk pulse when x wraps to 0.
- `frame_start` out 1: one-clk pulse when (x,y) wraps to (0,0).

## Operation
- Divider `div` counts 0..CLK_DIV-1 and wraps. `p_tick` = (div == CLK_DIV-1) decoded from the registered `div`. With CLK_DIV=1, `p_tick` is constantly high.
- Advance edge: a clk edge at which `p_tick` is high.
  - x increments, wrapping HT-1 → 0.
  - When x wraps, y increments, wrapping VT-1 → 0.
- Region order along each axis: active, front porch, sync, back porch.
  - hsync asserted for x in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC-1].
  - vsync asserted for y in [V_ACTIVE+V_FRONT, V_ACTIVE+V_FRONT+V_SYNC-1].
  - video_on = (x < H_ACTIVE) && (y < V_ACTIVE).
- Output level: asserted → POL, deasserted → ~POL.
- Sync and video decode is always registered, never driven combinationally to pins.
  - PIPE_DLY=0: decode is computed from the next-count values and registered on the same edge as x/y, so it is aligned with x/y.
  - PIPE_DLY=N: an N-stage shift register, advancing only on advance edges, follows that register.
- `line_start` is registered high for exactly the one clk cycle following an advance edge at which x went HT-1 → 0.
- `frame_start` is registered high for exactly the one clk cycle following an advance edge at which (x,y) went (HT-1,VT-1) → (0,0). A frame_start cycle is also a line_start cycle.
- `enable` low, at each clk edge: div, x, y and all pipeline stages clear to their reset values. No pulses are generated while enable is low.
- `enable` rising: counting restarts exactly as after reset. No frame_start is issued for the restart.

## Timing
Reset values (async, held while `reset` is high):
- div=0, so `p_tick`=0 (for CLK_DIV>1).
- x=0, y=0.
- hsync=~HSYNC_POL, vsync=~VSYNC_POL.
- video_on=0; pipeline stages cleared to deasserted/0.
- line_start=0, frame_start=0.

Timing after release:
- The first advance edge is the CLK_DIV-th clk edge after reset deasserts.
- The first frame_start follows edge HT·VT·CLK_DIV. With defaults that is 800·525·4 = 1,680,000.
- The output pipeline holds deasserted values until the first advance edge, after which decode follows normally.
- Reset or enable-low in mid-frame aborts the frame immediately; no partial pulse is stretched.
- `enable` and `reset` are not synchronised internally. The caller supplies `enable` synchronous to clk_100MHz.
- Latency:
  - x/y change 1 clk after the tick cycle.
  - hsync/vsync/video_on lag x/y by PIPE_DLY pixels (PIPE_DLY·CLK_DIV clks).

## Test plan
- Defaults, reset then run one frame:
  - p_tick period = 4 clks.
  - x sequence 0..799 then wraps; y 0..524.
  - frame_start first seen at clk 1,680,000, then every 1,680,000 clks.
  - line_start every 3200 clks.
- Defaults, sync decode:
  - hsync=0 exactly for x 656..751, otherwise 1.
  - vsync=0 exactly for y 490..491.
  - video_on=1 only for x<640 and y<480.
- HSYNC_POL=1, VSYNC_POL=1, PIPE_DLY=2:
  - hsync=1 while the x that was current 2 pixels earlier was in 656..751.
  - video_on falls when x=642.
- CLK_DIV=1, small mode (H 8/2/3/1, V 4/1/1/1):
  - p_tick constantly high.
  - HT=14, VT=7.
  - frame_start every 98 clks.
  - hsync asserted for x 10..12.
- Drop enable for 5 clks at x=300, y=200:
  - x=y=0, div=0, video_on=0, hsync/vsync deasserted during the gap.
  - No frame_start on restart.
  - Next frame_start comes 1,680,000 clks after enable rises.
- Assert reset at x=799, y=524 in the cycle before the wrap:
  - Outputs go to reset values immediately.
  - frame_start never pulses.
